// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if -- pipeline-side signal bundle for the hazard controller.
//   master : pipeline/datapath side. It drives the hazard inputs and receives the
//            stall, bubble and flush controls.
//   slave  : controller side (pipe_hazard_ctrl).
//   Inputs to the controller : em2reg, ewreg, ern, rs, rt, use_rs, use_rt,
//                              branch_taken, md_start, md_done, imem_ready, dmem_ready
//   Outputs from controller  : wpcir, bubble, flush_ifid, wexe, md_go, md_err,
//                              state, stall_cnt
interface pipe_hazard_ctrl_if;
   logic        em2reg;
   logic        ewreg;
   logic [4:0]  ern;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        use_rs;
   logic        use_rt;
   logic        branch_taken;
   logic        md_start;
   logic        md_done;
   logic        imem_ready;
   logic        dmem_ready;
   logic        wpcir;
   logic        bubble;
   logic        flush_ifid;
   logic        wexe;
   logic        md_go;
   logic        md_err;
   logic [1:0]  state;
   logic [31:0] stall_cnt;

   modport master (
      output em2reg, ewreg, ern, rs, rt, use_rs, use_rt, branch_taken,
             md_start, md_done, imem_ready, dmem_ready,
      input  wpcir, bubble, flush_ifid, wexe, md_go, md_err, state, stall_cnt
   );

   modport slave (
      input  em2reg, ewreg, ern, rs, rt, use_rs, use_rt, branch_taken,
             md_start, md_done, imem_ready, dmem_ready,
      output wpcir, bubble, flush_ifid, wexe, md_go, md_err, state, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- 5-stage pipeline hazard / stall controller.
//
// Responsibilities:
//   - Load-use interlock. A load in EX whose destination feeds the instruction
//     in ID stalls the front end for one cycle.
//   - Multi-cycle mul/div sequencing: RUN -> MDWAIT -> MDISS -> RUN. An 8-bit
//     watchdog aborts the wait after MD_TIMEOUT cycles and sets a sticky md_err.
//   - Global freeze while data memory is not ready.
//   - IF/ID flush on a taken branch when the front end advances.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   hif (slave)  : hazard inputs and pipeline control outputs (see pipe_hazard_ctrl_if)
// Parameters:
//   MD_TIMEOUT   : maximum number of mul/div wait cycles before abort (1..255)
// Build option:
//   PIPE_STALL_CNT_EN : when defined, stall_cnt is a saturating 32-bit count of
//                       cycles outside reset in which wpcir=0. When undefined,
//                       stall_cnt is tied to 0 and the design has no counter flops.
module pipe_hazard_ctrl #(
   parameter int unsigned MD_TIMEOUT = 63
) (
   input  logic             clock,
   input  logic             reset,
   pipe_hazard_ctrl_if.slave hif
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      MDWAIT = 2'd1,
      MDISS  = 2'd2
   } state_t;

   localparam logic [8:0] TIMEOUT = 9'(MD_TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] wd_q, wd_d;
   logic       err_q, err_d;
   logic       hz;
   logic       wpcir, bubble, wexe, md_go;

   // Load-use hazard. r0 is never a real dependency.
   assign hz = hif.em2reg & hif.ewreg & (hif.ern != 5'd0) &
               ((hif.use_rs & (hif.ern == hif.rs)) | (hif.use_rt & (hif.ern == hif.rt)));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         wd_q    <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wd_d    = wd_q;
      err_d   = err_q;
      wpcir   = 1'b0;
      bubble  = 1'b0;
      wexe    = 1'b0;
      md_go   = 1'b0;
      if (reset) begin
         bubble = 1'b1;
      end else if (hif.dmem_ready) begin
         // While dmem_ready is low every output stays at its default and all state holds.
         wexe = 1'b1;
         unique case (state_q)
            RUN: begin
               if (hz) begin
                  bubble = 1'b1;
               end else if (hif.md_start) begin
                  // The mul/div instruction stays in ID until the result is back.
                  md_go   = 1'b1;
                  bubble  = 1'b1;
                  state_d = MDWAIT;
                  wd_d    = 8'd0;
               end else if (!hif.imem_ready) begin
                  bubble = 1'b1;
               end else begin
                  wpcir = 1'b1;
               end
            end
            MDWAIT: begin
               bubble = 1'b1;
               if (wd_q != 8'hFF) wd_d = wd_q + 8'd1;
               // md_done takes precedence, so a result that arrives on the timeout
               // cycle does not raise md_err.
               if (hif.md_done) begin
                  state_d = MDISS;
               end else if (({1'b0, wd_q} + 9'd1) >= TIMEOUT) begin
                  err_d   = 1'b1;
                  state_d = MDISS;
               end
            end
            MDISS: begin
               wpcir   = hif.imem_ready;
               state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   assign hif.wpcir      = wpcir;
   assign hif.bubble     = bubble;
   assign hif.wexe       = wexe;
   assign hif.md_go      = md_go;
   assign hif.flush_ifid = hif.branch_taken & wpcir & ~bubble;
   assign hif.md_err     = err_q;
   assign hif.state      = state_q;

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clock) begin
      if (reset)
         stall_cnt_q <= 32'd0;
      else if (!wpcir && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign hif.stall_cnt = stall_cnt_q;
`else
   assign hif.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. It runs two instances on shared stimulus:
//   u0 uses MD_TIMEOUT=63 and u1 uses MD_TIMEOUT=3.
// A behavioural model per instance predicts the outputs, and every negedge
// compares them. Literal checks in the stimulus pin the model itself.
module tb_pipe_hazard_ctrl;
   logic clock = 1'b0;
   logic reset;
   int   nvec = 0;
   int   nerr = 0;
   bit   started = 0;

   always #5 clock = ~clock;

   pipe_hazard_ctrl_if ifa ();
   pipe_hazard_ctrl_if ifb ();

   assign ifb.em2reg       = ifa.em2reg;
   assign ifb.ewreg        = ifa.ewreg;
   assign ifb.ern          = ifa.ern;
   assign ifb.rs           = ifa.rs;
   assign ifb.rt           = ifa.rt;
   assign ifb.use_rs       = ifa.use_rs;
   assign ifb.use_rt       = ifa.use_rt;
   assign ifb.branch_taken = ifa.branch_taken;
   assign ifb.md_start     = ifa.md_start;
   assign ifb.md_done      = ifa.md_done;
   assign ifb.imem_ready   = ifa.imem_ready;
   assign ifb.dmem_ready   = ifa.dmem_ready;

   pipe_hazard_ctrl dut0 (.clock(clock), .reset(reset), .hif(ifa));
   pipe_hazard_ctrl #(.MD_TIMEOUT(3)) dut1 (.clock(clock), .reset(reset), .hif(ifb));

   // ---------------- behavioural model ----------------
   int              mst [2];   // 0 RUN, 1 waiting on mul/div, 2 issuing
   int              mwd [2];
   bit              merr[2];
   longint unsigned mcnt[2];

   function automatic int tmo(int m);
      return (m == 0) ? 63 : 3;
   endfunction

   function automatic bit load_use();
      return ifa.em2reg && ifa.ewreg && ifa.ern != 0 &&
             ((ifa.use_rs && ifa.ern == ifa.rs) || (ifa.use_rt && ifa.ern == ifa.rt));
   endfunction

   function automatic void model_out(input int m, output bit w, output bit b,
                                     output bit f, output bit x, output bit g);
      bit stall;
      w = 0; b = 0; x = 0; g = 0;
      if (reset) b = 1;
      else if (ifa.dmem_ready) begin
         x = 1;
         if (mst[m] == 0) begin
            stall = load_use() || ifa.md_start || !ifa.imem_ready;
            w = !stall;
            b = stall;
            g = !load_use() && ifa.md_start;
         end else if (mst[m] == 1) b = 1;
         else w = ifa.imem_ready;
      end
      f = ifa.branch_taken && w && !b;
   endfunction

   initial forever begin
      @(posedge clock);
      for (int m = 0; m < 2; m++) begin
         bit w, b, f, x, g;
         model_out(m, w, b, f, x, g);
         if (reset) begin
            mst[m] = 0; mwd[m] = 0; merr[m] = 0; mcnt[m] = 0;
         end else begin
            if (!w && mcnt[m] < 64'hFFFF_FFFF) mcnt[m] = mcnt[m] + 1;
            if (ifa.dmem_ready) begin
               case (mst[m])
                  0: if (g) begin mst[m] = 1; mwd[m] = 0; end
                  1: begin
                     if (mwd[m] < 255) mwd[m] = mwd[m] + 1;
                     if (ifa.md_done) mst[m] = 2;
                     else if (mwd[m] >= tmo(m)) begin merr[m] = 1; mst[m] = 2; end
                  end
                  default: mst[m] = 0;
               endcase
            end
         end
      end
      if (reset) started = 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare process: checks all outputs of both instances once the first reset is seen.
   initial forever begin
      @(negedge clock);
      if (started) begin
         for (int m = 0; m < 2; m++) begin
            bit w, b, f, x, g;
            logic [63:0] ecnt;
            model_out(m, w, b, f, x, g);
`ifdef PIPE_STALL_CNT_EN
            ecnt = mcnt[m];
`else
            ecnt = 64'd0;
`endif
            if (m == 0) begin
               chk("u0_wpcir", ifa.wpcir, w);      chk("u0_bubble", ifa.bubble, b);
               chk("u0_flush", ifa.flush_ifid, f); chk("u0_wexe", ifa.wexe, x);
               chk("u0_md_go", ifa.md_go, g);      chk("u0_md_err", ifa.md_err, merr[0]);
               chk("u0_state", ifa.state, mst[0]); chk("u0_stall_cnt", ifa.stall_cnt, ecnt);
            end else begin
               chk("u1_wpcir", ifb.wpcir, w);      chk("u1_bubble", ifb.bubble, b);
               chk("u1_flush", ifb.flush_ifid, f); chk("u1_wexe", ifb.wexe, x);
               chk("u1_md_go", ifb.md_go, g);      chk("u1_md_err", ifb.md_err, merr[1]);
               chk("u1_state", ifb.state, mst[1]); chk("u1_stall_cnt", ifb.stall_cnt, ecnt);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      ifa.em2reg = 0; ifa.ewreg = 0; ifa.ern = 0; ifa.rs = 0; ifa.rt = 0;
      ifa.use_rs = 0; ifa.use_rt = 0; ifa.branch_taken = 0; ifa.md_start = 0;
      ifa.md_done = 0; ifa.imem_ready = 1; ifa.dmem_ready = 1;
   endtask

   task automatic do_reset();
      tick(); reset = 1; idle();
      tick(); reset = 0;
   endtask

   initial begin
      logic [31:0] c5, c4;
`ifdef PIPE_STALL_CNT_EN
      c5 = 32'd5; c4 = 32'd4;
`else
      c5 = 32'd0; c4 = 32'd0;
`endif
      reset = 1; idle(); ifa.md_start = 1; ifa.branch_taken = 1;
      tick(); #2;
      chk("rst_wpcir", ifa.wpcir, 0); chk("rst_bubble", ifa.bubble, 1);
      chk("rst_wexe", ifa.wexe, 0);   chk("rst_md_go", ifa.md_go, 0);
      chk("rst_flush", ifa.flush_ifid, 0); chk("rst_state", ifa.state, 0);
      chk("rst_err", ifa.md_err, 0);

      tick(); reset = 0; idle(); #2; chk("idle_wpcir", ifa.wpcir, 1);
      // load-use through rs
      tick(); ifa.em2reg = 1; ifa.ewreg = 1; ifa.ern = 5; ifa.rs = 5; ifa.use_rs = 1; #2;
      chk("lu_wpcir", ifa.wpcir, 0); chk("lu_bubble", ifa.bubble, 1); chk("lu_wexe", ifa.wexe, 1);
      tick(); ifa.em2reg = 0; #2; chk("lu_next_wpcir", ifa.wpcir, 1);
      // r0 never stalls
      tick(); idle(); ifa.em2reg = 1; ifa.ewreg = 1; ifa.use_rs = 1; #2;
      chk("zr_wpcir", ifa.wpcir, 1); chk("zr_bubble", ifa.bubble, 0);
      // load-use through rt
      tick(); idle(); ifa.em2reg = 1; ifa.ewreg = 1; ifa.ern = 7; ifa.rt = 7; ifa.use_rt = 1; #2;
      chk("rt_bubble", ifa.bubble, 1);
      tick(); ifa.use_rt = 0; #2;
      tick(); idle(); ifa.em2reg = 1; ifa.ern = 9; ifa.rs = 9; ifa.use_rs = 1; #2;
      chk("noew_wpcir", ifa.wpcir, 1);
      // hazard masks md_start
      tick(); idle(); ifa.em2reg = 1; ifa.ewreg = 1; ifa.ern = 3; ifa.rs = 3; ifa.use_rs = 1;
      ifa.md_start = 1; #2; chk("hzmd_go", ifa.md_go, 0);
      tick(); idle(); #2; chk("hzmd_state", ifa.state, 0);
      // fetch stall and branch flush
      tick(); ifa.imem_ready = 0; ifa.branch_taken = 1; #2;
      chk("imem_wpcir", ifa.wpcir, 0); chk("imem_flush", ifa.flush_ifid, 0);
      tick(); ifa.imem_ready = 1; #2; chk("br_flush", ifa.flush_ifid, 1);
      tick(); idle(); ifa.md_done = 1; #2;
      tick(); idle(); #2; chk("done_ign_state", ifa.state, 0);

      // mul/div completion on the 4th wait cycle; u1 times out after 3
      do_reset(); ifa.md_start = 1; #2; chk("md_go", ifa.md_go, 1);
      tick(); ifa.md_start = 0; #2; chk("md_w1", ifa.state, 1); chk("md_go_once", ifa.md_go, 0);
      tick(); #2; chk("md_w2", ifa.state, 1);
      tick(); #2; chk("md_w3", ifa.state, 1);
      tick(); ifa.md_done = 1; #2; chk("md_w4", ifa.state, 1);
      chk("to_iss", ifb.state, 2); chk("to_err", ifb.md_err, 1);
      tick(); ifa.md_done = 0; #2; chk("md_iss", ifa.state, 2); chk("md_iss_wpcir", ifa.wpcir, 1);
      chk("to_run", ifb.state, 0);
      tick(); #2; chk("md_run", ifa.state, 0); chk("md_err0", ifa.md_err, 0);
      chk("md_cnt", ifa.stall_cnt, c5); chk("to_cnt", ifb.stall_cnt, c4);

      // memory freeze during the wait; u1 watchdog must not advance
      do_reset(); ifa.md_start = 1;
      tick(); ifa.md_start = 0;
      tick();
      tick(); ifa.dmem_ready = 0; #2;
      chk("frz_wexe", ifa.wexe, 0); chk("frz_wpcir", ifa.wpcir, 0); chk("frz_u1_state", ifb.state, 1);
      tick(); tick(); #2; chk("frz_u1_hold", ifb.state, 1);
      tick(); ifa.dmem_ready = 1; #2; chk("frz_u1_w3", ifb.state, 1); chk("frz_u1_err0", ifb.md_err, 0);
      tick(); #2; chk("frz_u1_iss", ifb.state, 2); chk("frz_u1_err", ifb.md_err, 1);
      tick(); ifa.md_done = 1;
      tick(); ifa.md_done = 0; #2; chk("frz_u0_iss", ifa.state, 2);

      // md_start held off by freeze, then reset in the middle of the wait
      tick(); idle(); ifa.md_start = 1; ifa.dmem_ready = 0; #2; chk("frz_go", ifa.md_go, 0);
      tick(); ifa.dmem_ready = 1; #2; chk("frz_go_rel", ifa.md_go, 1);
      tick(); ifa.md_start = 0;
      tick(); reset = 1; #2; chk("mrst_go", ifa.md_go, 0); chk("mrst_bubble", ifa.bubble, 1);
      tick(); reset = 0; #2; chk("mrst_state", ifa.state, 0); chk("mrst_go2", ifa.md_go, 0);

      // md_done coincides with the u1 timeout: no error raised
      tick(); ifa.md_start = 1;
      tick(); ifa.md_start = 0;
      tick();
      tick(); ifa.md_done = 1;
      tick(); ifa.md_done = 0; #2; chk("tie_state", ifb.state, 2); chk("tie_err", ifb.md_err, 0);
      tick(); tick(); #2;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 63, max mul/div wait cycles before abort (range 1..255).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- em2reg  in  1  EX-stage instruction is a load.
- ewreg  in  1  EX-stage instruction writes the register file.
- ern  in  5  EX-stage destination register.
- rs, rt  in  5 each  ID-stage source registers.
- use_rs, use_rt  in  1 each  ID instruction reads rs / rt.
- branch_taken  in  1  ID resolved a taken branch or jump.
- md_start  in  1  ID holds a mul/div instruction.
- md_done  in  1  mul/div unit result ready, 1-cycle pulse.
- imem_ready  in  1  instruction fetch valid this cycle.
- dmem_ready  in  1  data memory completes this cycle.
- wpcir  out  1  PC and IF/ID register write enable.
- bubble  out  1  force ID control signals to zero into ID/EX.
- flush_ifid  out  1  load NOP into IF/ID.
- wexe  out  1  ID/EX, EX/MEM and MEM/WB write enable.
- md_go  out  1  mul/div unit start pulse.
- md_err  out  1  sticky mul/div timeout flag.
- state  out  2  FSM state: 0=RUN, 1=MDWAIT, 2=MDISS.
- stall_cnt  out  32  stall-cycle count (see Configuration).

Function
REQ-003 SHALL compute hz = em2reg & ewreg & (ern!=0) & ((use_rs & ern==rs) | (use_rt & ern==rt)), combinationally.
REQ-004 SHALL apply, in priority order, each cycle:
- dmem_ready=0: wpcir=0, wexe=0, bubble=0, flush_ifid=0, md_go=0; state and watchdog hold.
- RUN, hz=1: wpcir=0, bubble=1, wexe=1 (one-cycle load-use stall; md_start ignored this cycle).
- RUN, md_start=1: md_go=1 for exactly this cycle, wpcir=0, bubble=1, wexe=1; next state MDWAIT.
- RUN, imem_ready=0: wpcir=0, bubble=1, wexe=1.
- RUN otherwise: wpcir=1, bubble=0, wexe=1.
- MDWAIT: wpcir=0, bubble=1, wexe=1; md_done=1 -> MDISS; watchdog reaching MD_TIMEOUT -> md_err=1 and next state MDISS.
- MDISS: wpcir=imem_ready, bubble=0, wexe=1, md_go=0; next state RUN (mul/div instruction advances to EX).
REQ-005 SHALL drive flush_ifid = branch_taken & wpcir & ~bubble.
REQ-006 SHALL clear the 8-bit watchdog on entry to MDWAIT, increment it each non-frozen MDWAIT cycle, never wrap.
REQ-007 SHALL ignore md_done outside MDWAIT; md_done and timeout in the same cycle -> MDISS with md_err unchanged.
REQ-008 SHALL keep md_err set until reset.
REQ-009 SHALL never assert md_go in consecutive cycles.
REQ-010 SHALL make all outputs glitch-free functions of registered state and current inputs; no combinational loop through wpcir.

Reset
REQ-011 SHALL, while reset=1 at a rising edge, set state=RUN, watchdog=0, md_err=0, stall_cnt=0.
REQ-012 SHALL drive wpcir=0, wexe=0, bubble=1, flush_ifid=0, md_go=0 while reset=1, regardless of inputs.
REQ-013 SHALL abandon an in-progress MDWAIT on reset with no md_go re-issue.

Configuration
REQ-014 SHALL compile stall_cnt logic only when PIPE_STALL_CNT_EN is defined: counts cycles with reset=0 and wpcir=0, saturating at 0xFFFFFFFF.
REQ-015 SHALL tie stall_cnt to 0 and instantiate no counter flops when PIPE_STALL_CNT_EN is undefined.

Verification
REQ-016 Load-use: em2reg=1, ewreg=1, ern=5, rs=5, use_rs=1 -> one cycle wpcir=0, bubble=1; next cycle (em2reg=0) wpcir=1.
REQ-017 Zero register: same as REQ-016 with ern=0, rs=0 -> wpcir=1, bubble=0 (no stall).
REQ-018 Mul/div: md_start=1 in RUN, md_done after 4 cycles -> md_go pulse once, state 1 for 4 cycles, then state 2, then 0; stall_cnt=5 (macro defined).
REQ-019 Timeout: MD_TIMEOUT=3, md_done never -> md_err=1 after 3 MDWAIT cycles, state returns to RUN via MDISS.
REQ-020 Memory freeze: dmem_ready=0 for 3 cycles during MDWAIT -> wexe=0, state/watchdog frozen; branch_taken=1 in RUN with wpcir=1 -> flush_ifid=1; reset mid-MDWAIT -> state=0, md_go=0.
